fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 70 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: imem address generator feeding a 2-entry instruction buffer,
// with one-cycle flush on redirect and ready/valid handoff to decode.
module fetch_stage #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [31:0]       imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, infl_pc_q;
  logic              infl_q, issue, pop, push, redir, widx;
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] pc_q [2];
  assign imem_address = addr_q;
  assign out_valid    = count_q != 2'd0;
  assign out_instr    = instr_q[head_q];
  assign out_pc       = pc_q[head_q];
  always_comb begin
    pop     = out_valid && out_ready;
    redir   = redirect_valid && state_q == RUN;
    push    = infl_q && !redir;
    widx    = head_q ^ count_q[0];
    // a slot must remain for every fetch already in flight
    issue   = fetch_en && (state_q == FLUSH || (state_q == RUN && !redirect_valid)) &&
              (3'(count_q) + 3'(infl_q) < 3'd2 + 3'(pop));
    head_d  = head_q ^ pop;
    count_d = redir ? 2'd0 : count_q + 2'(push) - 2'(pop);
    addr_d  = redir ? redirect_pc : issue ? addr_q + 1'b1 : addr_q;
    state_d = state_q == IDLE  ? (fetch_en ? RUN : IDLE) :
              state_q == FLUSH ? RUN :
              redirect_valid   ? FLUSH :
              (!fetch_en && !infl_q) ? IDLE : RUN;
  end
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q   <= IDLE;
      addr_q    <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      head_q    <= 1'b0;
      count_q   <= 2'd0;
      instr_q   <= '{default: '0};
      pc_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      infl_q    <= issue;
      infl_pc_q <= addr_q;
      head_q    <= head_d;
      count_q   <= count_d;
      if (push) begin
        instr_q[widx] <= imem_q;
        pc_q[widx]    <= infl_pc_q;
      end
    end
  end
endmodule
